// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART transmit path
package uart_pkg;

   typedef enum logic [1:0] {
      PARITY_NONE = 2'd0,
      PARITY_ODD  = 2'd1,
      PARITY_EVEN = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

   localparam int MAX_DATA_BITS = 9;

   // Unused data bits must be zero; the NONE result is never transmitted.
   function automatic logic calc_parity(input parity_e mode,
                                        input logic [MAX_DATA_BITS-1:0] data);
      return (mode == PARITY_ODD) ? ~(^data) : (^data);
   endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - enqueue handshake, status and serial line of the transmitter
interface uart_tx_fifo_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4
);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [DATA_BITS-1:0] i_data;
   logic                 i_valid;
   logic                 o_ready;
   logic [CNT_W-1:0]     o_count;
   logic                 o_busy;
   logic                 o_tx;

   modport slave  (input  i_data, i_valid, output o_ready, o_count, o_busy, o_tx);
   modport master (output i_data, i_valid, input  o_ready, o_count, o_busy, o_tx);

endinterface

// File: rtl/strobe_div.sv
// rtl/strobe_div.sv - free-running divider emitting a one-cycle strobe every DIV cycles
module strobe_div #(
   parameter int DIV = 4
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   output logic o_strobe
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] r_cnt;

   assign o_strobe = (r_cnt == CW'(DIV - 1)) && !i_clear;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         r_cnt <= '0;
      else if (i_clear || o_strobe)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + 1'b1;
   end

endmodule

// File: rtl/uart_tx_fifo_mem.sv
// rtl/uart_tx_fifo_mem.sv - synchronous FIFO with show-ahead head word
module uart_tx_fifo_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_push,
   input  logic [WIDTH-1:0]             i_data,
   input  logic                         i_pop,
   output logic [WIDTH-1:0]             o_data,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   // Pop is judged on the pre-edge count, so a word written into an empty FIFO waits a cycle.
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];

   always_ff @(posedge i_clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter: FIFO feeding a start/data/parity/stop framer
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int      BAUD_DIV   = 10417,
   parameter int      DATA_BITS  = 8,
   parameter parity_e PARITY     = PARITY_NONE,
   parameter int      STOP_BITS  = 1,
   parameter int      FIFO_DEPTH = 4
) (
   input  logic            i_clk,
   input  logic            i_reset,
   uart_tx_fifo_if.slave   bus
);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   if (BAUD_DIV < 2) begin : g_bad_baud
      $error("uart_tx_fifo: BAUD_DIV must be >= 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_fifo: DATA_BITS must be 5..9");
   end
   if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_parity
      $error("uart_tx_fifo: PARITY must be NONE, ODD or EVEN");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
   end

   tx_state_e            r_state;
   tx_state_e            w_next_state;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par;
   logic [3:0]           r_bit;
   logic [DATA_BITS-1:0] w_head;
   logic [CNT_W-1:0]     w_count;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_strobe;
   logic                 w_div_clear;
   logic                 w_tx;

   assign w_push      = bus.i_valid && !w_full;
   assign w_div_clear = (r_state == ST_IDLE);

   uart_tx_fifo_mem #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_mem (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (w_push),
      .i_data  (bus.i_data),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   strobe_div #(
      .DIV (BAUD_DIV)
   ) u_div (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_clear  (w_div_clear),
      .o_strobe (w_strobe)
   );

   always_comb begin
      w_next_state = r_state;
      w_pop        = 1'b0;
      w_tx         = 1'b1;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_next_state = ST_START;
            end
         end
         ST_START: begin
            w_tx = 1'b0;
            if (w_strobe)
               w_next_state = ST_DATA;
         end
         ST_DATA: begin
            w_tx = r_shift[0];
            if (w_strobe && r_bit == 4'(DATA_BITS - 1))
               w_next_state = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
         end
         ST_PARITY: begin
            w_tx = r_par;
            if (w_strobe)
               w_next_state = ST_STOP;
         end
         ST_STOP: begin
            // Last stop cycle chains straight into the next start bit when words are waiting.
            if (w_strobe && r_bit == 4'(STOP_BITS - 1)) begin
               if (!w_empty) begin
                  w_pop        = 1'b1;
                  w_next_state = ST_START;
               end else begin
                  w_next_state = ST_IDLE;
               end
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_bit   <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_pop) begin
            r_shift <= w_head;
            r_par   <= calc_parity(PARITY, MAX_DATA_BITS'(w_head));
            r_bit   <= '0;
         end else if (w_strobe) begin
            if (r_state == ST_DATA)
               r_shift <= r_shift >> 1;
            if (w_next_state != r_state)
               r_bit <= '0;
            else if (r_state == ST_DATA || r_state == ST_STOP)
               r_bit <= r_bit + 1'b1;
         end
      end
   end

   assign bus.o_tx    = w_tx;
   assign bus.o_ready = !w_full;
   assign bus.o_count = w_count;
   assign bus.o_busy  = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;
   import uart_pkg::*;

   localparam int BD = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_e2 ();
   uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_od ();
   uart_tx_fifo_if #(.DATA_BITS(5), .FIFO_DEPTH(4)) if_d5 ();

   uart_tx_fifo #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(PARITY_EVEN), .STOP_BITS(2), .FIFO_DEPTH(4))
      u_e2 (.i_clk(clk), .i_reset(rst), .bus(if_e2));
   uart_tx_fifo #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(PARITY_ODD), .STOP_BITS(1), .FIFO_DEPTH(4))
      u_od (.i_clk(clk), .i_reset(rst), .bus(if_od));
   uart_tx_fifo #(.BAUD_DIV(BD), .DATA_BITS(5), .PARITY(PARITY_NONE), .STOP_BITS(1), .FIFO_DEPTH(4))
      u_d5 (.i_clk(clk), .i_reset(rst), .bus(if_d5));

   function automatic logic tx_of(input int sel);
      case (sel)
         0:       return if_e2.o_tx;
         1:       return if_od.o_tx;
         default: return if_d5.o_tx;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push(input int sel, input logic [8:0] d);
      case (sel)
         0:       begin if_e2.i_valid = 1'b1; if_e2.i_data = d[7:0]; end
         1:       begin if_od.i_valid = 1'b1; if_od.i_data = d[7:0]; end
         default: begin if_d5.i_valid = 1'b1; if_d5.i_data = d[4:0]; end
      endcase
      tick();
      if_e2.i_valid = 1'b0;
      if_od.i_valid = 1'b0;
      if_d5.i_valid = 1'b0;
   endtask

   task automatic wait_start(input int sel, input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < max_cyc && !ok; k++) begin
         tick();
         if (tx_of(sel) == 1'b0)
            ok = 1'b1;
      end
   endtask

   task automatic capture(input int sel, input int nbits, output logic [15:0] got, output int glitches);
      got      = '0;
      glitches = 0;
      for (int i = 0; i < nbits; i++) begin
         for (int c = 0; c < BD; c++) begin
            logic s;
            s = tx_of(sel);
            if (c == 0)
               got[i] = s;
            else if (s !== got[i])
               glitches++;
            tick();
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({if_e2.o_tx, if_e2.o_busy, if_e2.o_count} !== {1'b1, 1'b0, 3'd0}) begin
         failures++;
         $display("FAIL reset_e2 got tx=%b busy=%b count=%0d want tx=1 busy=0 count=0",
                  if_e2.o_tx, if_e2.o_busy, if_e2.o_count);
      end
      checks++;
      if ({if_od.o_tx, if_od.o_busy, if_od.o_count} !== {1'b1, 1'b0, 3'd0}) begin
         failures++;
         $display("FAIL reset_od got tx=%b busy=%b count=%0d want tx=1 busy=0 count=0",
                  if_od.o_tx, if_od.o_busy, if_od.o_count);
      end
      checks++;
      if ({if_d5.o_tx, if_d5.o_busy, if_d5.o_count} !== {1'b1, 1'b0, 3'd0}) begin
         failures++;
         $display("FAIL reset_d5 got tx=%b busy=%b count=%0d want tx=1 busy=0 count=0",
                  if_d5.o_tx, if_d5.o_busy, if_d5.o_count);
      end
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if ({if_e2.o_ready, if_od.o_ready, if_d5.o_ready} !== 3'b111) begin
         failures++;
         $display("FAIL reset_ready got %b want 111", {if_e2.o_ready, if_od.o_ready, if_d5.o_ready});
      end
   endtask

   task automatic test_even_a5();
      logic [15:0] got;
      int          gl;
      bit          ok;
      push(0, 9'h0A5);
      checks++;
      if ({if_e2.o_tx, if_e2.o_busy, if_e2.o_count} !== {1'b1, 1'b1, 3'd1}) begin
         failures++;
         $display("FAIL a5_after_accept got tx=%b busy=%b count=%0d want tx=1 busy=1 count=1",
                  if_e2.o_tx, if_e2.o_busy, if_e2.o_count);
      end
      wait_start(0, 1, ok);
      checks++;
      if (ok !== 1'b1) begin
         failures++;
         $display("FAIL a5_start_latency got no start bit one edge after accept want start bit");
      end
      capture(0, 12, got, gl);
      checks++;
      if (got[11:0] !== 12'hD4A) begin
         failures++;
         $display("FAIL a5_frame got %b want %b (bit0 first on right)", got[11:0], 12'hD4A);
      end
      checks++;
      if (gl !== 0) begin
         failures++;
         $display("FAIL a5_bit_width got %0d unstable samples want 0", gl);
      end
      checks++;
      if ({if_e2.o_busy, if_e2.o_tx} !== 2'b01) begin
         failures++;
         $display("FAIL a5_idle_after got busy=%b tx=%b want busy=0 tx=1", if_e2.o_busy, if_e2.o_tx);
      end
   endtask

   task automatic test_parity();
      logic [15:0] got;
      int          gl;
      bit          ok;
      push(1, 9'h000);
      wait_start(1, 1, ok);
      capture(1, 11, got, gl);
      checks++;
      if (!ok || got[10:0] !== 11'h600 || gl != 0) begin
         failures++;
         $display("FAIL odd_00_frame got ok=%b frame=%b glitches=%0d want ok=1 frame=%b glitches=0",
                  ok, got[10:0], gl, 11'h600);
      end
      push(0, 9'h000);
      wait_start(0, 1, ok);
      capture(0, 12, got, gl);
      checks++;
      if (!ok || got[11:0] !== 12'hC00 || gl != 0) begin
         failures++;
         $display("FAIL even_00_frame got ok=%b frame=%b glitches=%0d want ok=1 frame=%b glitches=0",
                  ok, got[11:0], gl, 12'hC00);
      end
   endtask

   task automatic test_data5();
      logic [15:0] got;
      int          gl;
      bit          ok;
      push(2, 9'h01F);
      wait_start(2, 1, ok);
      capture(2, 7, got, gl);
      checks++;
      if (!ok || got[6:0] !== 7'h7E || gl != 0) begin
         failures++;
         $display("FAIL d5_1f_frame got ok=%b frame=%b glitches=%0d want ok=1 frame=%b glitches=0",
                  ok, got[6:0], gl, 7'h7E);
      end
      checks++;
      if ({if_d5.o_busy, if_d5.o_tx} !== 2'b01) begin
         failures++;
         $display("FAIL d5_idle_after got busy=%b tx=%b want busy=0 tx=1", if_d5.o_busy, if_d5.o_tx);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] words [6];
      logic [7:0] sb [$];
      int         pushed;
      int         full_ready_bad;
      bit         saw_full;
      words = '{8'h11, 8'h22, 8'h3C, 8'h80, 8'hFF, 8'h5A};
      pushed = 0;
      full_ready_bad = 0;
      saw_full = 1'b0;
      fork
         begin
            int n;
            int cyc;
            n = 0;
            cyc = 0;
            if_od.i_valid = 1'b1;
            if_od.i_data  = words[0];
            while (n < 6 && cyc < 400) begin
               bit rdy;
               rdy = if_od.o_ready;
               if (if_od.o_count == 3'd4) begin
                  saw_full = 1'b1;
                  if (rdy)
                     full_ready_bad++;
               end
               tick();
               cyc++;
               if (rdy) begin
                  sb.push_back(words[n]);
                  n++;
                  if (n < 6)
                     if_od.i_data = words[n];
               end
            end
            if_od.i_valid = 1'b0;
            pushed = n;
         end
         begin
            bit          ok;
            logic [15:0] got;
            logic [10:0] exp;
            logic [7:0]  w;
            int          gl;
            wait_start(1, 20, ok);
            checks++;
            if (!ok) begin
               failures++;
               $display("FAIL b2b_first_start got no start bit within 20 cycles want start bit");
            end else begin
               for (int f = 0; f < 6; f++) begin
                  capture(1, 11, got, gl);
                  w = (sb.size() > 0) ? sb.pop_front() : 8'h00;
                  exp = {1'b1, ~^w, w, 1'b0};
                  checks++;
                  if (got[10:0] !== exp || gl != 0) begin
                     failures++;
                     $display("FAIL b2b_frame%0d got frame=%b glitches=%0d want frame=%b glitches=0",
                              f, got[10:0], gl, exp);
                  end
               end
            end
         end
      join
      checks++;
      if (pushed != 6 || sb.size() != 0) begin
         failures++;
         $display("FAIL b2b_scoreboard got pushed=%0d leftover=%0d want pushed=6 leftover=0", pushed, sb.size());
      end
      checks++;
      if (!saw_full || full_ready_bad != 0) begin
         failures++;
         $display("FAIL b2b_ready_full got saw_full=%b ready_while_full=%0d want saw_full=1 ready_while_full=0",
                  saw_full, full_ready_bad);
      end
      checks++;
      if ({if_od.o_busy, if_od.o_tx, if_od.o_count} !== {1'b0, 1'b1, 3'd0}) begin
         failures++;
         $display("FAIL b2b_idle_after got busy=%b tx=%b count=%0d want busy=0 tx=1 count=0",
                  if_od.o_busy, if_od.o_tx, if_od.o_count);
      end
   endtask

   task automatic test_reset_midframe();
      int bad;
      push(1, 9'h001);
      push(1, 9'h002);
      push(1, 9'h003);
      repeat (8) tick();
      checks++;
      if ({if_od.o_tx, if_od.o_count} !== {1'b0, 3'd2}) begin
         failures++;
         $display("FAIL midframe_pre got tx=%b count=%0d want tx=0 count=2", if_od.o_tx, if_od.o_count);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({if_od.o_tx, if_od.o_busy, if_od.o_count} !== {1'b1, 1'b0, 3'd0}) begin
         failures++;
         $display("FAIL midframe_reset got tx=%b busy=%b count=%0d want tx=1 busy=0 count=0",
                  if_od.o_tx, if_od.o_busy, if_od.o_count);
      end
      @(negedge clk);
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if (if_od.o_ready !== 1'b1) begin
         failures++;
         $display("FAIL midframe_ready got %b want 1", if_od.o_ready);
      end
      bad = 0;
      for (int k = 0; k < 120; k++) begin
         if (if_od.o_tx !== 1'b1 || if_od.o_busy !== 1'b0)
            bad++;
         tick();
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL midframe_no_resend got %0d active cycles want 0", bad);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      if_e2.i_valid = 1'b0; if_e2.i_data = '0;
      if_od.i_valid = 1'b0; if_od.i_data = '0;
      if_d5.i_valid = 1'b0; if_d5.i_data = '0;
      test_reset();
      test_even_a5();
      test_parity();
      test_data5();
      test_back_to_back();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
